// File: rtl/data_memory_pipelined_pkg.sv
// data_memory_pipelined_pkg: shared word size, FSM states and response record for the data memory
package data_memory_pipelined_pkg;
  localparam int WORD_SIZE = 19;
  localparam int RD_LAT_MAX = 4;
  typedef enum logic {DM_CLEAR, DM_READY} dmem_state_t;
  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [WORD_SIZE-1:0] rdata;
  } dmem_rsp_t;
endpackage

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe: fixed-latency response shift register, emptied by reset
module dmem_rsp_pipe
  import data_memory_pipelined_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  dmem_rsp_t i_rsp,
  output dmem_rsp_t o_rsp
);
  dmem_rsp_t r_pipe [RD_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= i_rsp;
      for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end
  assign o_rsp = r_pipe[RD_LAT-1];
endmodule

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: word RAM with valid/ready requests, range check,
// fixed read latency and an optional post-reset zeroing sweep
module data_memory_pipelined
  import data_memory_pipelined_pkg::*;
#(
  parameter int DATA_W         = WORD_SIZE,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 19,
  parameter int RD_LAT         = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int AW  = $clog2(DEPTH);
  localparam int LAT = RD_LAT > RD_LAT_MAX ? RD_LAT_MAX : (RD_LAT < 1 ? 1 : RD_LAT);
  dmem_state_t       r_state, w_state_nxt;
  logic [AW-1:0]     r_clr_ptr;
  logic              r_rst_q;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_in_range, w_accept, w_clr_last;
  logic [AW-1:0]     w_idx;
  dmem_rsp_t         w_rsp_in, w_rsp_out;
  // full-width compare so high address bits can never alias into the array
  assign w_in_range = 64'(req_addr) < 64'(DEPTH);
  assign w_idx      = req_addr[AW-1:0];
  assign busy       = r_state == DM_CLEAR;
  assign req_ready  = r_state == DM_READY && !r_rst_q;
  assign w_accept   = req_valid && req_ready && !rst;
  assign w_clr_last = r_clr_ptr == AW'(DEPTH - 1);
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = rst ? (CLEAR_ON_RESET != 0 ? DM_CLEAR : DM_READY)
                : (busy && w_clr_last) ? DM_READY : r_state;
  end
  always_ff @(posedge clk) begin
    r_state   <= w_state_nxt;
    r_rst_q   <= rst;
    r_clr_ptr <= (rst || !busy) ? '0 : r_clr_ptr + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (busy && !rst) r_mem[r_clr_ptr] <= '0;
    else if (w_accept && req_we && w_in_range) r_mem[w_idx] <= req_wdata;
  end
  always_comb begin
    w_rsp_in       = '0;
    w_rsp_in.valid = w_accept;
    w_rsp_in.err   = w_accept && !w_in_range;
    w_rsp_in.rdata = (w_accept && !req_we && w_in_range) ? WORD_SIZE'(r_mem[w_idx]) : '0;
  end
  dmem_rsp_pipe #(.RD_LAT(LAT)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .i_rsp(w_rsp_in),
    .o_rsp(w_rsp_out)
  );
  assign rsp_valid = w_rsp_out.valid;
  assign rsp_err   = w_rsp_out.err;
  assign rsp_rdata = DATA_W'(w_rsp_out.rdata);
endmodule

// File: doc/data_memory_pipelined.md
Name: data_memory_pipelined

Overview:
Parametrised successor of the single-cycle CPU data memory. It is a word-addressed RAM with a valid/ready request handshake, a configurable read-response latency, an address range check with an error flag, and an optional post-reset clear sequence. It sits between the load/store unit and the memory array and replaces the fixed 1024 x WORD_SIZE block.

Parameters:
DATA_W, WORD_SIZE (19), data word width
DEPTH, 1024, number of words; any value >= 2, not required to be a power of two
ADDR_W, 19, width of the request address (full CPU address width)
RD_LAT, 2, response latency in cycles; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset, 0 = contents survive reset

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response present (single-cycle pulse per request)
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  address out of range (req_addr >= DEPTH)
busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst high at an edge):
  - Next cycle: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - The response pipeline is flushed; in-flight responses are dropped and never emitted.
  - The FSM goes to DM_CLEAR if CLEAR_ON_RESET=1, otherwise to DM_READY.
  - busy=1 from the first cycle after reset exactly when entering DM_CLEAR.
- FSM, DM_CLEAR:
  - clr_ptr starts at 0. Each cycle write 0 to mem[clr_ptr], then increment.
  - After writing DEPTH-1, move to DM_READY. Clear takes exactly DEPTH cycles.
  - busy=1 and req_ready=0 throughout.
  - rst asserted mid-clear restarts the sequence at clr_ptr=0.
- FSM, DM_READY:
  - req_ready=1, busy=0. There is no response backpressure.
  - One request may be accepted per cycle.
- Accept: a request is accepted on an edge where req_valid && req_ready.
- In-range write (req_addr < DEPTH): mem[req_addr] <= req_wdata at the accept edge.
- Any accepted request produces exactly one response.
- Latency: a request accepted at edge n gives rsp_valid=1 during the cycle following edge n+RD_LAT-1. With RD_LAT=1 this matches the old single-cycle behaviour.
- Response payload:
  - In-range read: rsp_rdata = mem[addr], sampled at the accept edge; rsp_err=0.
  - Write: rsp_rdata=0, rsp_err=0.
  - Out-of-range (either op): no array access, rsp_rdata=0, rsp_err=1.
- Ordering: responses return in request order. Back-to-back requests give back-to-back responses.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. Intermediate responses are never stale.
- Address compare: full ADDR_W compare against DEPTH; no truncation or aliasing. Array index uses the low $clog2(DEPTH) bits only after the range check passes.
- Idle: rsp_rdata and rsp_err are held at 0 whenever rsp_valid=0.

Decomposition:
- Shared package:
  - WORD_SIZE (existing)
  - dmem_state_t enum {DM_CLEAR, DM_READY}
  - dmem_rsp_t struct {valid, err, rdata[WORD_SIZE]}
  - RD_LAT_MAX = 4
- Sub-module dmem_rsp_pipe:
  - Parametrised RD_LAT-deep shift register of dmem_rsp_t, flushed by rst.
  - Stage 0 is loaded from the array read at the accept edge.
- The top level holds the FSM, the clear pointer, the range check and the array.

Test Plan:
1. Clear sequence (DEPTH=16, CLEAR_ON_RESET=1): rst for 1 cycle -> busy=1 and req_ready=0 for exactly 16 cycles, then req_ready=1. Reads of addresses 0..15 all return 0.
2. Write then read (RD_LAT=2): write 0x5A5A5 to addr 3, then read addr 3 the next cycle -> write response (err=0, rdata=0) 2 cycles after the write; read response rdata=0x5A5A5 2 cycles after the read.
3. Streaming reads: read addrs 0,1,2,3 on consecutive cycles after writing 0x10..0x13 -> four consecutive rsp_valid pulses with rdata 0x10,0x11,0x12,0x13 in order.
4. Out of range (DEPTH=16): write 0x7FFFF to addr 16, then read addr 0x40000 -> both responses err=1, rdata=0. A later read of addr 0 returns its prior value, unchanged.
5. Reset mid-flight: accept a read of addr 5, assert rst on the next edge -> no rsp_valid ever appears for that read. With CLEAR_ON_RESET=0, a later read of addr 5 returns its pre-reset value.
6. Reset mid-clear: assert rst at clear cycle 7 -> the clear restarts, busy lasts a further 16 cycles, and all words read back 0.
